// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch path: word geometry and fetch FSM encoding.
package instruction_fetch_unit_pkg;

   localparam int BYTES_PER_INSTRUCTION = 5;
   localparam int INSTRUCTION_WIDTH     = 8 * BYTES_PER_INSTRUCTION;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_byte_assembler.sv
// Shift-in assembler: bytes enter at the top of a shadow register so the first byte ends in [7:0];
// the visible word is only written on load, never with a partial value.
module fetch_byte_assembler #(
   parameter int BYTES = instruction_fetch_unit_pkg::BYTES_PER_INSTRUCTION
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 capture,
   input  logic                 load,
   input  logic [7:0]           data,
   output logic [8*BYTES-1:0]   word
);

   localparam int W = 8 * BYTES;

   logic [W-1:0] shadow;
   logic [W-1:0] shifted;

   assign shifted = {data, shadow[W-1:8]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow <= '0;
         word   <= '0;
      end else begin
         if (clear)
            shadow <= '0;
         else if (capture)
            shadow <= shifted;
         // load coincides with the final capture, so take the shifted value directly
         if (load)
            word <= shifted;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches one multi-byte instruction from a 1-cycle-latency byte memory and presents it as a word.
//
// state | meaning
// IDLE  | waiting for fetchRequest
// ISSUE | one byte read strobe per cycle, address incrementing
// DRAIN | reads issued, collecting the remaining in-flight bytes
// DONE  | instructionBuffer valid, Complete pulse high
module instruction_fetch_unit #(
   parameter int BYTES_PER_INSTRUCTION = instruction_fetch_unit_pkg::BYTES_PER_INSTRUCTION,
   parameter int ADDRESS_WIDTH         = 32
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 fetchRequest,
   input  logic [ADDRESS_WIDTH-1:0]             instructionAddress,
   input  logic                                 flush,
   output logic                                 busy,
   output logic                                 memReadEnable,
   output logic [ADDRESS_WIDTH-1:0]             memAddress,
   input  logic [7:0]                           memReadData,
   output logic [8*BYTES_PER_INSTRUCTION-1:0]   instructionBuffer,
   output logic                                 readInstructionStarting,
   output logic                                 readInstructionCompleting,
   output logic                                 readInstructionComplete
);

   import instruction_fetch_unit_pkg::*;

   localparam logic [2:0] LAST = 3'(BYTES_PER_INSTRUCTION);

   fetch_state_e state;
   logic [2:0]   issue_cnt;
   logic [2:0]   cap_cnt;
   logic         rd_pending;
   logic         accept;
   logic         clear;
   logic         load;

   assign accept = (state == IDLE) && fetchRequest && !flush;
   assign clear  = flush || accept;
   assign load   = (state == DRAIN) && rd_pending && (cap_cnt == LAST - 3'd1) && !flush;

   fetch_byte_assembler #(
      .BYTES(BYTES_PER_INSTRUCTION)
   ) u_assembler (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .capture (rd_pending),
      .load    (load),
      .data    (memReadData),
      .word    (instructionBuffer)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                     <= IDLE;
         busy                      <= 1'b0;
         memReadEnable             <= 1'b0;
         memAddress                <= '0;
         readInstructionStarting   <= 1'b0;
         readInstructionCompleting <= 1'b0;
         readInstructionComplete   <= 1'b0;
         issue_cnt                 <= '0;
         cap_cnt                   <= '0;
         rd_pending                <= 1'b0;
      end else begin
         readInstructionStarting   <= 1'b0;
         readInstructionCompleting <= 1'b0;
         readInstructionComplete   <= 1'b0;
         rd_pending                <= memReadEnable;
         if (rd_pending)
            cap_cnt <= cap_cnt + 3'd1;

         if (flush && state != IDLE) begin
            state         <= IDLE;
            busy          <= 1'b0;
            memReadEnable <= 1'b0;
            rd_pending    <= 1'b0;
            issue_cnt     <= '0;
            cap_cnt       <= '0;
         end else begin
            // memory data trails the strobe by one cycle, so the last byte arrives one cycle before DONE
            if (rd_pending && cap_cnt == LAST - 3'd2)
               readInstructionCompleting <= 1'b1;
            case (state)
               IDLE: begin
                  if (accept) begin
                     state                   <= ISSUE;
                     busy                    <= 1'b1;
                     memReadEnable           <= 1'b1;
                     memAddress              <= instructionAddress;
                     issue_cnt               <= 3'd1;
                     cap_cnt                 <= '0;
                     readInstructionStarting <= 1'b1;
                  end
               end
               ISSUE: begin
                  if (issue_cnt == LAST) begin
                     memReadEnable <= 1'b0;
                     state         <= DRAIN;
                  end else begin
                     memAddress <= memAddress + ADDRESS_WIDTH'(1);
                     issue_cnt  <= issue_cnt + 3'd1;
                  end
               end
               DRAIN: begin
                  if (load) begin
                     state                   <= DONE;
                     readInstructionComplete <= 1'b1;
                     issue_cnt               <= '0;
                     cap_cnt                 <= '0;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
